mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Select-line sequencer that sits directly upstream of the parameterizable N:1 mux (mux with parameters N, M and ports y, sel, I).
- Drives the mux `sel` and samples its 1-bit `y` output one channel per clock.
- Skips channels that are masked off.
- Assembles the sampled bits into an N-bit word and presents it with a one-cycle valid strobe.
- Supports single-shot scans and continuous scans.

Parameters:
N, 4, number of mux data inputs / channels; also the width of the result word.
M, 2, select width; must satisfy N <= 2**M (checked at elaboration).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  scan request; honoured only in IDLE
cont  input  1  continuous mode; sampled in DONE
chan_en  input  N  per-channel enable mask; latched on scan start
y  input  1  mux output, combinational function of sel
sel  output  M  channel select to the mux, registered
word  output  N  last completed scan result; bit i = sampled I[i], 0 if channel disabled
valid  output  1  one-cycle strobe; word is new
busy  output  1  high while state is SCAN

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - sel=0, word=0, valid=0, busy=0.
  - The latched mask and the shadow word are cleared.
  - rst overrides every other input, including mid-scan. An aborted scan never asserts valid and leaves word=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - sel=0, busy=0, valid=0.
  - On start=1, chan_en is latched into en_q and the shadow word is cleared.
  - If en_q≠0: next state is SCAN, with sel loaded with the lowest enabled index.
  - If en_q=0: next state is DONE, with word=0.
- SCAN:
  - busy=1.
  - Each cycle, y is combinational from the current sel and is captured into shadow[sel] at the clock edge.
  - sel then advances to the next higher enabled index in en_q; disabled indices are never driven.
  - After the highest enabled index is captured:
    - word <= shadow, including the bit captured on that same edge.
    - State goes to DONE.
    - sel returns to 0.
  - start is ignored in SCAN. chan_en changes have no effect until the next scan start.
- DONE:
  - valid=1 for exactly this one cycle; busy=0.
  - If cont=1: relatch chan_en, clear the shadow, and proceed exactly as a start from IDLE (next state SCAN, or DONE again if the mask is 0).
  - If cont=0: next state is IDLE. A start asserted during DONE is ignored.
- Latency: with K enabled channels and start high in cycle T:
  - sel visits channels in cycles T+1 .. T+K.
  - valid=1 and word is updated in cycle T+K+1.
  - With K=0, valid is asserted at T+1.
  - Continuous scan period is K+1 cycles, or 1 cycle when K=0.
- word holds its value between scans; it changes only on DONE entry or on rst.
- Next-index search is a combinational priority search over en_q above the current sel. sel never exceeds N-1, even when N<2**M.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with random inputs -> sel=0, word=0, valid=0, busy=0; start held high during rst has no effect.
2. Full scan, N=4, M=2, I=4'b1010 behind the mux, chan_en=4'b1111, start pulse in cycle 0 -> sel=0,1,2,3 in cycles 1-4; busy=1 in cycles 1-4; cycle 5 valid=1, word=4'b1010; cycle 6 back in IDLE.
3. Sparse mask, I=4'b1111, chan_en=4'b0101 -> sel=0,2 in cycles 1-2; sel never 1 or 3; cycle 3 valid=1, word=4'b0101.
4. Empty mask, chan_en=4'b0000, start in cycle 0 -> busy stays 0; cycle 1 valid=1, word=4'b0000.
5. Continuous mode and ignored start:
   - Setup: cont=1, chan_en=4'b1111; I=4'b0011 for the first scan, changed to 4'b1100 at cycle 3; extra start pulses in cycle 2.
   - Required: valid in cycle 5 with word=4'b??11, where the upper bits reflect I at their sample cycles (exactly 4'b1111 with the timing above).
   - Required: the second scan starts with sel=0 in cycle 6, and valid pulses in cycle 10 with word=4'b1100.
   - Required: the start pulses in cycle 2 are ignored.
6. Mid-scan reset, chan_en=4'b1111, start in cycle 0, rst=1 in cycle 2 -> cycle 3 IDLE, sel=0, busy=0; valid never pulses; word stays 0; a fresh start after rst runs a normal scan.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Select-line sequencer for an N:1 mux: walks the enabled channels one per clock,
// collects the mux output into an N-bit word and strobes valid when a scan completes.
//
// state | meaning
// IDLE  | waiting for start, sel parked at 0
// SCAN  | driving sel through enabled channels, capturing y each edge
// DONE  | one-cycle valid; relaunch when cont=1, else back to IDLE
module mux_scan_ctrl #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cont,
  input  logic [N-1:0] chan_en,
  input  logic         y,
  output logic [M-1:0] sel,
  output logic [N-1:0] word,
  output logic         valid,
  output logic         busy
);

  if (N > (2 ** M)) begin : g_param_check
    $error("mux_scan_ctrl: N must not exceed 2**M");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t       state, state_nx;
  logic [M-1:0] sel_nx;
  logic [N-1:0] en_q, en_nx;
  logic [N-1:0] shadow, shadow_nx, shadow_cap;
  logic [N-1:0] word_nx;
  logic         first_found, next_found;
  logic [M-1:0] first_idx, next_idx;
  logic         launch;

  // Priority searches: lowest enabled channel of the incoming mask, and the
  // next enabled channel above sel in the latched mask.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (chan_en[i]) begin
        first_found = 1'b1;
        first_idx   = i[M-1:0];
      end
      if (en_q[i] && (i > int'(sel))) begin
        next_found = 1'b1;
        next_idx   = i[M-1:0];
      end
    end
  end

  always_comb begin
    shadow_cap = shadow;
    for (int i = 0; i < N; i++) begin
      if (i == int'(sel)) shadow_cap[i] = y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      en_q   <= '0;
      shadow <= '0;
      word   <= '0;
    end else begin
      state  <= state_nx;
      sel    <= sel_nx;
      en_q   <= en_nx;
      shadow <= shadow_nx;
      word   <= word_nx;
    end
  end

  assign launch = ((state == IDLE) && start) || ((state == DONE) && cont);

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    en_nx     = en_q;
    shadow_nx = shadow;
    word_nx   = word;
    case (state)
      IDLE, DONE: begin
        sel_nx = '0;
        if (launch) begin
          en_nx     = chan_en;
          shadow_nx = '0;
          if (first_found) begin
            state_nx = SCAN;
            sel_nx   = first_idx;
          end else begin
            state_nx = DONE;
            word_nx  = '0;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      SCAN: begin
        shadow_nx = shadow_cap;
        if (next_found) begin
          sel_nx = next_idx;
        end else begin
          // last enabled channel: publish including the bit captured now
          word_nx  = shadow_cap;
          state_nx = DONE;
          sel_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        sel_nx   = '0;
      end
    endcase
  end

  always_comb begin
    valid = (state == DONE);
    busy  = (state == SCAN);
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: table of single-shot scans plus hand-written
// sequences for reset, continuous mode and mid-scan abort.
module tb_mux_scan_ctrl;

  localparam int N = 4;
  localparam int M = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cont;
  logic [N-1:0] chan_en;
  logic         y;
  logic [M-1:0] sel;
  logic [N-1:0] word;
  logic         valid;
  logic         busy;
  logic [N-1:0] din;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign y = din[sel];

  mux_scan_ctrl #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .chan_en(chan_en),
    .y(y), .sel(sel), .word(word), .valid(valid), .busy(busy)
  );

  typedef struct {
    logic [3:0]      din;
    logic [3:0]      en;
    int              k;
    logic [3:0][1:0] sels;
    logic [3:0]      exp_word;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0] = '{din: 4'b1010, en: 4'b1111, k: 4, sels: {2'd3, 2'd2, 2'd1, 2'd0}, exp_word: 4'b1010};
    vecs[1] = '{din: 4'b1111, en: 4'b0101, k: 2, sels: {2'd0, 2'd0, 2'd2, 2'd0}, exp_word: 4'b0101};
    vecs[2] = '{din: 4'b1111, en: 4'b0000, k: 0, sels: {2'd0, 2'd0, 2'd0, 2'd0}, exp_word: 4'b0000};
    vecs[3] = '{din: 4'b0110, en: 4'b1000, k: 1, sels: {2'd0, 2'd0, 2'd0, 2'd3}, exp_word: 4'b0000};
    vecs[4] = '{din: 4'b1001, en: 4'b1001, k: 2, sels: {2'd0, 2'd0, 2'd3, 2'd0}, exp_word: 4'b1001};
    vecs[5] = '{din: 4'b0101, en: 4'b1110, k: 3, sels: {2'd0, 2'd3, 2'd2, 2'd1}, exp_word: 4'b0100};

    // reset with noisy inputs and start held high
    rst = 1'b1; start = 1'b1; cont = 1'b1;
    chan_en = 4'($urandom); din = 4'($urandom);
    step();
    chan_en = 4'($urandom); din = 4'($urandom);
    step();
    chk("rst_sel", sel, 0);
    chk("rst_word", word, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0; start = 1'b0; cont = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);

    foreach (vecs[v]) begin
      din = vecs[v].din;
      chan_en = vecs[v].en;
      start = 1'b1;
      step();
      start = 1'b0;
      chan_en = ~vecs[v].en;
      for (int j = 0; j < vecs[v].k; j++) begin
        chk($sformatf("v%0d_sel%0d", v, j), sel, vecs[v].sels[j]);
        chk($sformatf("v%0d_busy%0d", v, j), busy, 1);
        chk($sformatf("v%0d_novalid%0d", v, j), valid, 0);
        step();
      end
      chk($sformatf("v%0d_valid", v), valid, 1);
      chk($sformatf("v%0d_done_busy", v), busy, 0);
      chk($sformatf("v%0d_word", v), word, vecs[v].exp_word);
      start = 1'b1;
      step();
      start = 1'b0;
      chk($sformatf("v%0d_idle_valid", v), valid, 0);
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
      chk($sformatf("v%0d_idle_sel", v), sel, 0);
      chk($sformatf("v%0d_word_hold", v), word, vecs[v].exp_word);
    end

    // continuous mode with input change mid-scan and ignored start pulses
    cont = 1'b1; chan_en = 4'b1111; din = 4'b0011; start = 1'b1;
    step();
    start = 1'b0;
    chk("c1_sel", sel, 0);
    step();
    start = 1'b1;
    chk("c2_sel", sel, 1);
    step();
    start = 1'b0; din = 4'b1100;
    chk("c3_sel", sel, 2);
    chk("c3_busy", busy, 1);
    step();
    chk("c4_sel", sel, 3);
    step();
    chk("c5_valid", valid, 1);
    chk("c5_word", word, 4'b1111);
    step();
    chk("c6_sel", sel, 0);
    chk("c6_busy", busy, 1);
    chk("c6_novalid", valid, 0);
    step();
    chk("c7_sel", sel, 1);
    step();
    chk("c8_sel", sel, 2);
    step();
    chk("c9_sel", sel, 3);
    step();
    chk("c10_valid", valid, 1);
    chk("c10_word", word, 4'b1100);
    cont = 1'b0;
    step();
    chk("c11_valid", valid, 0);
    chk("c11_busy", busy, 0);

    // continuous with empty mask: valid every cycle
    cont = 1'b1; chan_en = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    chk("ce1_valid", valid, 1);
    chk("ce1_word", word, 0);
    step();
    chk("ce2_valid", valid, 1);
    chk("ce2_busy", busy, 0);
    cont = 1'b0;
    step();
    chk("ce3_valid", valid, 0);

    // mid-scan reset
    rst = 1'b1;
    step();
    rst = 1'b0; chan_en = 4'b1111; din = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    chk("mr1_busy", busy, 1);
    step();
    rst = 1'b1;
    chk("mr2_sel", sel, 1);
    step();
    rst = 1'b0;
    chk("mr3_sel", sel, 0);
    chk("mr3_busy", busy, 0);
    chk("mr3_valid", valid, 0);
    chk("mr3_word", word, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("mr_novalid%0d", j), valid, 0);
      chk($sformatf("mr_word0_%0d", j), word, 0);
    end
    din = 4'b0110; start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("mr_rescan_sel%0d", j), sel, j);
      step();
    end
    chk("mr_rescan_valid", valid, 1);
    chk("mr_rescan_word", word, 4'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
